alu_result_bcd: RTL

Sequential consumer of the ALU's 8-bit result bus. It converts the binary or two's-complement result into a sign flag plus three BCD digits (hundreds, tens, ones) for the seven-segment display path. It uses a start/busy/done handshake and a double-dabble shift-add-3 engine. It sits between the alu result output and the display multiplexer.

---
 rtl/alu_result_bcd.sv | 92 +++++++++
 1 files changed

// File: rtl/alu_result_bcd.sv
// ALU result to sign + 3-digit BCD converter.
// Double-dabble engine behind a start/busy/done handshake.
module alu_result_bcd #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] result,
  input  logic         signed_mode,
  output logic         busy,
  output logic         done,
  output logic         neg,
  output logic [3:0]   bcd_hund,
  output logic [3:0]   bcd_tens,
  output logic [3:0]   bcd_ones
);

  localparam int CW = $clog2(W);
  localparam int SW = W + 12;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic [SW-1:0] scr;
  logic [SW-1:0] scr_nx;
  logic [CW-1:0] cnt;
  logic          sign_r;
  logic          is_neg;
  logic [W-1:0]  mag;
  logic [3:0]    h_a;
  logic [3:0]    t_a;
  logic [3:0]    o_a;

  assign is_neg = signed_mode & result[W-1];
  assign mag    = is_neg ? (~result + 1'b1) : result;

  always_comb begin
    h_a = scr[SW-1:SW-4];
    t_a = scr[SW-5:SW-8];
    o_a = scr[SW-9:SW-12];
    if (h_a >= 4'd5) h_a = h_a + 4'd3;
    if (t_a >= 4'd5) t_a = t_a + 4'd3;
    if (o_a >= 4'd5) o_a = o_a + 4'd3;
    scr_nx = {h_a, t_a, o_a, scr[W-1:0]} << 1;
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      scr      <= '0;
      cnt      <= '0;
      sign_r   <= 1'b0;
      neg      <= 1'b0;
      bcd_hund <= 4'd0;
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign_r <= is_neg;
            scr    <= {12'b0, mag};
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          scr <= scr_nx;
          cnt <= cnt + 1'b1;
          // outputs take the final shifted value on the same edge
          if (cnt == LAST) begin
            state    <= DONE;
            neg      <= sign_r;
            bcd_hund <= scr_nx[SW-1:SW-4];
            bcd_tens <= scr_nx[SW-5:SW-8];
            bcd_ones <= scr_nx[SW-9:SW-12];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
